// File: rtl/alu.sv
// Multi-group multiply-free filter ALU: signed shift-add/subtract accumulation over NUM_RJ coefficient groups.
// Define ALU_SAT_EN to saturate MAC results; without it the accumulator wraps modulo 2^ACC_W.
module alu #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int NUM_RJ = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic [7:0]        current_data_addr,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] coeff_data,
    input  logic [7:0]        rj_data,
    output logic [7:0]        data_addr,
    output logic [8:0]        coeff_addr,
    output logic [3:0]        rj_addr,
    output logic              output_en,
    output logic [ACC_W-1:0]  accum_reg
);

    // state   | meaning
    // IDLE    | waiting for enable; result of last run held
    // LOAD_RJ | latch coefficient count of group rj_addr
    // MAC     | one add/subtract of a delayed sample per cycle
    // SHIFT   | arithmetic halving after each group
    // DONE    | result valid; wait for enable to drop
    typedef enum logic [2:0] {IDLE, LOAD_RJ, MAC, SHIFT, DONE} state_t;

    localparam int FRAC_W = 16;
    localparam int PAD_W  = ACC_W - DATA_W - FRAC_W;

    state_t           state, state_nxt;
    logic [7:0]       count, count_nxt;
    logic [ACC_W-1:0] accum_nxt;
    logic [8:0]       coeff_addr_nxt;
    logic [3:0]       rj_addr_nxt;
    logic             output_en_nxt;
    logic [ACC_W-1:0] operand;
    logic [ACC_W-1:0] mac_res;
    logic             unused_coeff_bits;

    assign unused_coeff_bits = ^coeff_data[DATA_W-1:9];
    assign data_addr = current_data_addr - coeff_data[7:0];
    assign operand   = {{PAD_W{data[DATA_W-1]}}, data, {FRAC_W{1'b0}}};

`ifdef ALU_SAT_EN
    logic [ACC_W:0] sum_wide;

    always_comb begin
        if (coeff_data[8])
            sum_wide = {accum_reg[ACC_W-1], accum_reg} - {operand[ACC_W-1], operand};
        else
            sum_wide = {accum_reg[ACC_W-1], accum_reg} + {operand[ACC_W-1], operand};
        // Extra sign bit disagreeing with the result MSB means the 40-bit result overflowed
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
            mac_res = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            mac_res = sum_wide[ACC_W-1:0];
    end
`else
    always_comb begin
        if (coeff_data[8])
            mac_res = accum_reg - operand;
        else
            mac_res = accum_reg + operand;
    end
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            accum_reg  <= '0;
            coeff_addr <= '0;
            rj_addr    <= '0;
            output_en  <= 1'b0;
            count      <= '0;
        end else begin
            state      <= state_nxt;
            accum_reg  <= accum_nxt;
            coeff_addr <= coeff_addr_nxt;
            rj_addr    <= rj_addr_nxt;
            output_en  <= output_en_nxt;
            count      <= count_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        accum_nxt      = accum_reg;
        coeff_addr_nxt = coeff_addr;
        rj_addr_nxt    = rj_addr;
        count_nxt      = count;
        output_en_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    accum_nxt      = '0;
                    coeff_addr_nxt = '0;
                    rj_addr_nxt    = '0;
                    state_nxt      = LOAD_RJ;
                end
            end
            LOAD_RJ: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    count_nxt = rj_data;
                    state_nxt = (rj_data != 8'd0) ? MAC : SHIFT;
                end
            end
            MAC: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    accum_nxt      = mac_res;
                    coeff_addr_nxt = coeff_addr + 9'd1;
                    count_nxt      = count - 8'd1;
                    if (count == 8'd1)
                        state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    accum_nxt   = {accum_reg[ACC_W-1], accum_reg[ACC_W-1:1]};
                    rj_addr_nxt = rj_addr + 4'd1;
                    if (rj_addr == 4'(NUM_RJ - 1)) begin
                        state_nxt     = DONE;
                        output_en_nxt = 1'b1;
                    end else begin
                        state_nxt = LOAD_RJ;
                    end
                end
            end
            DONE: begin
                if (!enable)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: reset, add/subtract, multi-group, address wrap, abort, clear, saturation.
module tb_alu;

    logic        clk;
    logic        clear;
    logic        enable;
    logic [7:0]  current_data_addr;
    logic [15:0] data;
    logic [15:0] coeff_data;
    logic [7:0]  rj_data;
    logic [7:0]  data_addr;
    logic [8:0]  coeff_addr;
    logic [3:0]  rj_addr;
    logic        output_en;
    logic [39:0] accum_reg;

    logic [15:0] data_mem  [256];
    logic [15:0] coeff_mem [512];
    logic [7:0]  rj_mem    [16];

    int checks = 0;
    int errors = 0;

    alu dut (
        .clk              (clk),
        .clear            (clear),
        .enable           (enable),
        .current_data_addr(current_data_addr),
        .data             (data),
        .coeff_data       (coeff_data),
        .rj_data          (rj_data),
        .data_addr        (data_addr),
        .coeff_addr       (coeff_addr),
        .rj_addr          (rj_addr),
        .output_en        (output_en),
        .accum_reg        (accum_reg)
    );

    assign data       = data_mem[data_addr];
    assign coeff_data = coeff_mem[coeff_addr];
    assign rj_data    = rj_mem[rj_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) data_mem[i] = 16'h0;
        for (int i = 0; i < 512; i++) coeff_mem[i] = 16'h0;
        for (int i = 0; i < 16; i++) rj_mem[i] = 8'h0;
    endtask

    // Waits for output_en with a cycle budget, then checks latency, result, pulse width and hold.
    task automatic wait_done(input string tag, input int exp_lat, input logic [39:0] exp_acc);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 2000) begin
            step();
            n++;
            if (output_en) seen = 1;
        end
        check_val({tag, "_seen"}, 64'(seen), 64'd1);
        check_val({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check_val({tag, "_accum"}, 64'(accum_reg), 64'(exp_acc));
        step();
        check_val({tag, "_pulse_width"}, 64'(output_en), 64'd0);
        check_val({tag, "_hold"}, 64'(accum_reg), 64'(exp_acc));
        enable = 1'b0;
        step();
    endtask

    task automatic run(input string tag, input int exp_lat, input logic [39:0] exp_acc);
        enable = 1'b1;
        wait_done(tag, exp_lat, exp_acc);
    endtask

    initial begin
        clear = 1'b1;
        enable = 1'b0;
        current_data_addr = 8'd35;
        clear_mem();
        coeff_mem[0] = 16'h0030;
        step();
        step();
        check_val("rst_accum", 64'(accum_reg), 64'd0);
        check_val("rst_output_en", 64'(output_en), 64'd0);
        check_val("rst_coeff_addr", 64'(coeff_addr), 64'd0);
        check_val("rst_rj_addr", 64'(rj_addr), 64'd0);
        check_val("rst_data_addr", 64'(data_addr), 64'hF3);
        clear = 1'b0;
        step();

        // single add in group 0: 0x0100 << 16, halved 16 times
        clear_mem();
        rj_mem[0] = 8'd1;
        data_mem[35] = 16'h0100;
        run("add", 34, 40'h0000000100);
        check_val("add_coeff_addr", 64'(coeff_addr), 64'd1);
        check_val("add_rj_addr", 64'(rj_addr), 64'd0);

        // subtract in last group, delay 1: -(2 << 16) >>> 1
        clear_mem();
        rj_mem[15] = 8'd1;
        coeff_mem[0] = 16'h0101;
        data_mem[34] = 16'h0002;
        run("sub", 34, 40'hFFFFFF0000);

        // group 0: +0x100 -0x40 -> 0xC0; group 3: -256 >>> 13 -> -2048; total -1856
        clear_mem();
        rj_mem[0] = 8'd2;
        rj_mem[3] = 8'd1;
        coeff_mem[0] = 16'h0000;
        coeff_mem[1] = 16'h0105;
        coeff_mem[2] = 16'hFE03;
        data_mem[35] = 16'h0100;
        data_mem[30] = 16'h0040;
        data_mem[32] = 16'hFF00;
        run("multi", 36, 40'hFFFFFFF8C0);
        check_val("multi_coeff_addr", 64'(coeff_addr), 64'd3);

        // delay 0x30 below address 35 wraps to 0xF3
        clear_mem();
        rj_mem[0] = 8'd3;
        for (int i = 0; i < 3; i++) coeff_mem[i] = 16'h0030;
        data_mem[8'hF3] = 16'h0001;
        enable = 1'b1;
        step();
        step();
        check_val("wrap_data_addr", 64'(data_addr), 64'hF3);
        check_val("wrap_coeff_addr0", 64'(coeff_addr), 64'd0);
        step();
        check_val("wrap_coeff_addr1", 64'(coeff_addr), 64'd1);
        step();
        check_val("wrap_coeff_addr2", 64'(coeff_addr), 64'd2);
        step();
        check_val("wrap_coeff_addr3", 64'(coeff_addr), 64'd3);
        wait_done("wrap", 31, 40'h0000000003);

        // abort after first MAC cycle, then restart from scratch
        enable = 1'b1;
        step();
        step();
        step();
        enable = 1'b0;
        step();
        check_val("abort_output_en", 64'(output_en), 64'd0);
        check_val("abort_accum_held", 64'(accum_reg), 64'h10000);
        check_val("abort_coeff_addr", 64'(coeff_addr), 64'd1);
        step();
        check_val("abort_idle_output_en", 64'(output_en), 64'd0);
        check_val("abort_idle_accum", 64'(accum_reg), 64'h10000);
        enable = 1'b1;
        step();
        check_val("restart_coeff_addr", 64'(coeff_addr), 64'd0);
        check_val("restart_rj_addr", 64'(rj_addr), 64'd0);
        check_val("restart_accum", 64'(accum_reg), 64'd0);
        wait_done("restart", 35, 40'h0000000003);

        // clear mid-operation wins over a held-high enable
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step();
        clear = 1'b1;
        step();
        check_val("midclr_accum", 64'(accum_reg), 64'd0);
        check_val("midclr_coeff_addr", 64'(coeff_addr), 64'd0);
        check_val("midclr_rj_addr", 64'(rj_addr), 64'd0);
        check_val("midclr_output_en", 64'(output_en), 64'd0);
        clear = 1'b0;
        enable = 1'b0;
        step();

        // 255 adds in group 14, 129 in group 15 of 0x7FFF: crosses 2^39 before the last shift
        clear_mem();
        rj_mem[14] = 8'd255;
        rj_mem[15] = 8'd129;
        data_mem[35] = 16'h7FFF;
`ifdef ALU_SAT_EN
        run("sat", 417, 40'h3FFFFFFFFF);
        check_val("sat_sign", 64'(accum_reg[39]), 64'd0);
`else
        run("sat", 417, 40'hC01F7FC000);
        check_val("sat_sign", 64'(accum_reg[39]), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
